// File: rtl/count_1596_pkg.sv
// Shared types and constants for the count_1596 sweep sequencer.
package count_1596_pkg;

  localparam int unsigned CNT_W = 10;

  // Counter direction encoding as seen on cnt_updn.
  localparam logic UP   = 1'b0;
  localparam logic DOWN = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DWELL,
    FINISH
  } seq_state_t;

endpackage

// File: rtl/count_1596.sv
// 10-bit up/down counter driven by the sweep sequencer; load has priority over enable.
module count_1596 #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk5m,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic             updn,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise step in the requested direction when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = data_in;
    end else if (en) begin
      cnt_d = updn ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk5m) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/count_1596_seq.sv
// Sweep sequencer for count_1596: single or triangle sweeps between lo and hi with endpoint dwell.
module count_1596_seq
  import count_1596_pkg::*;
#(
  parameter int unsigned WIDTH   = CNT_W,
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned SWEEP_W = 8
) (
  input  logic               clk5m,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic               dir_init,
  input  logic [WIDTH-1:0]   lo_val,
  input  logic [WIDTH-1:0]   hi_val,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [SWEEP_W-1:0] n_sweeps,
  input  logic [WIDTH-1:0]   cnt,
  output logic               cnt_en,
  output logic               cnt_load,
  output logic               cnt_updn,
  output logic [WIDTH-1:0]   cnt_data,
  output logic               busy,
  output logic               done,
  output logic               err
);

  seq_state_t         state_q, state_d;
  logic               mode_q, mode_d;
  logic               dir_q, dir_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   spt_q, spt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic [SWEEP_W-1:0] nsw_q, nsw_d;
  logic [SWEEP_W-1:0] swc_q, swc_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   target;
  logic               end_sweep;

  // The target endpoint follows the current direction, so toggling dir_q swaps it.
  assign target = (dir_q == DOWN) ? lo_q : hi_q;

  // Next-state logic: program capture, sweep/dwell sequencing and the end-of-sweep decision.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    dir_d     = dir_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    spt_d     = spt_q;
    dwell_d   = dwell_q;
    dcnt_d    = dcnt_q;
    nsw_d     = nsw_q;
    swc_d     = swc_q;
    err_d     = err_q;
    end_sweep = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (lo_val > hi_val) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            mode_d  = mode;
            dir_d   = dir_init;
            lo_d    = lo_val;
            hi_d    = hi_val;
            spt_d   = (dir_init == DOWN) ? hi_val : lo_val;
            dwell_d = dwell;
            nsw_d   = n_sweeps;
            swc_d   = n_sweeps;
            state_d = LOAD;
          end
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (cnt == target) begin
          if (dwell_q != '0) begin
            dcnt_d  = DWELL_W'(1);
            state_d = DWELL;
          end else begin
            end_sweep = 1'b1;
          end
        end
      end
      DWELL: begin
        if (dcnt_q == dwell_q) end_sweep = 1'b1;
        else                   dcnt_d = dcnt_q + 1'b1;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Endless triangles never touch the sweep counter; counted ones stop when it reaches zero.
    if (end_sweep) begin
      if (!mode_q) begin
        state_d = FINISH;
      end else if (nsw_q == '0) begin
        dir_d   = ~dir_q;
        state_d = RUN;
      end else if (swc_q == SWEEP_W'(1)) begin
        swc_d   = '0;
        state_d = FINISH;
      end else begin
        swc_d   = swc_q - 1'b1;
        dir_d   = ~dir_q;
        state_d = RUN;
      end
    end

    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  // State and configuration registers with synchronous active-low reset.
  always_ff @(posedge clk5m) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      dir_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      spt_q   <= '0;
      dwell_q <= '0;
      dcnt_q  <= '0;
      nsw_q   <= '0;
      swc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      spt_q   <= spt_d;
      dwell_q <= dwell_d;
      dcnt_q  <= dcnt_d;
      nsw_q   <= nsw_d;
      swc_q   <= swc_d;
      err_q   <= err_d;
    end
  end

  // Counter controls; abort masks enable and load in its own cycle so the counter freezes at once.
  always_comb begin
    cnt_en   = (state_q == RUN) && (cnt != target) && !abort;
    cnt_load = (state_q == LOAD) && !abort;
  end

  assign cnt_updn = dir_q;
  assign cnt_data = spt_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);
  assign err      = err_q;

endmodule

// File: tb/tb_count_1596_seq.sv
// Self-checking bench: sequencer plus counter, checked every cycle against a sweep-list model.
module tb_count_1596_seq;
  import count_1596_pkg::*;

  logic       clk5m = 1'b0;
  logic       rst_n, start, abort, mode, dir_init;
  logic [9:0] lo_val, hi_val, cnt, cnt_data;
  logic [7:0] dwell, n_sweeps;
  logic       cnt_en, cnt_load, cnt_updn, busy, done, err;

  always #100 clk5m = ~clk5m;

  count_1596_seq #(.WIDTH(10), .DWELL_W(8), .SWEEP_W(8)) dut (
    .clk5m(clk5m), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .dir_init(dir_init), .lo_val(lo_val), .hi_val(hi_val), .dwell(dwell),
    .n_sweeps(n_sweeps), .cnt(cnt), .cnt_en(cnt_en), .cnt_load(cnt_load),
    .cnt_updn(cnt_updn), .cnt_data(cnt_data), .busy(busy), .done(done), .err(err)
  );

  count_1596 #(.WIDTH(10)) u_cnt (
    .clk5m(clk5m), .rst_n(rst_n), .en(cnt_en), .load(cnt_load), .updn(cnt_updn),
    .data_in(cnt_data), .cnt(cnt)
  );

  typedef struct {
    logic       busy, en, load, updn, done;
    logic [9:0] data, cnt;
  } rec_t;

  rec_t       q[$];
  int         checks = 0, errors = 0;
  int         tot_busy = 0, tot_en = 0, tot_load = 0, tot_done = 0, tot_tog = 0;
  int         s_busy, s_en, s_load, s_done, s_tog;
  logic [9:0] last_load_data = '0;
  logic       prev_updn = 1'b0;
  logic       model_ok = 1'b0;
  logic [9:0] m_cnt = '0, m_data = '0;
  logic       m_updn = 1'b0, m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(input logic b, input logic e, input logic l, input logic u,
                              input logic d, input logic [9:0] dt, input logic [9:0] c);
    rec_t r;
    r.busy = b; r.en = e; r.load = l; r.updn = u; r.done = d; r.data = dt; r.cnt = c;
    return r;
  endfunction

  // Expand an accepted program into the list of per-cycle outputs it must produce.
  task automatic build(input logic md, input logic dr, input logic [9:0] lo, input logic [9:0] hi,
                       input int dw, input int n);
    logic       d;
    logic [9:0] sp;
    int         pos, tgt, rem;
    d = dr; sp = dr ? hi : lo; tgt = dr ? lo : hi; pos = sp; rem = n;
    q.push_back(mk(1, 0, 1, d, 0, sp, m_cnt));
    forever begin
      forever begin
        q.push_back(mk(1, pos != tgt, 0, d, 0, sp, 10'(pos)));
        if (pos == tgt) break;
        pos = pos + (d ? -1 : 1);
      end
      for (int i = 0; i < dw; i++) q.push_back(mk(1, 0, 0, d, 0, sp, 10'(tgt)));
      if (!md) break;
      if (n != 0) begin
        rem--;
        if (rem == 0) break;
      end
      if (q.size() > 3000) break;
      d = ~d;
      tgt = d ? lo : hi;
    end
    q.push_back(mk(1, 0, 0, d, 1, sp, 10'(tgt)));
  endtask

  // One clock: compare at the falling edge, then return just after the next rising edge.
  task automatic tick();
    rec_t e;
    logic idle;
    @(negedge clk5m);
    if (model_ok) begin
      idle = (q.size() == 0);
      if (!idle) e = q.pop_front();
      else       e = mk(0, 0, 0, m_updn, 0, m_data, m_cnt);
      if (abort && e.busy) begin
        e.en = 1'b0; e.load = 1'b0;
      end
      chk("busy", busy, e.busy);
      chk("cnt_en", cnt_en, e.en);
      chk("cnt_load", cnt_load, e.load);
      chk("cnt_updn", cnt_updn, e.updn);
      chk("done", done, e.done);
      chk("cnt_data", cnt_data, e.data);
      chk("cnt", cnt, e.cnt);
      chk("err", err, m_err);
      tot_busy += int'(busy); tot_en += int'(cnt_en);
      tot_load += int'(cnt_load); tot_done += int'(done);
      if (cnt_load) last_load_data = cnt_data;
      if (busy && (cnt_updn != prev_updn)) tot_tog++;
      prev_updn = cnt_updn;
      m_cnt = e.cnt; m_data = e.data; m_updn = e.updn;
      if (abort && e.busy) q.delete();
      if (idle && start && !abort && rst_n) begin
        m_err = (lo_val > hi_val);
        if (!m_err) build(mode, dir_init, lo_val, hi_val, int'(dwell), int'(n_sweeps));
      end
      if (!rst_n) begin
        q.delete();
        m_cnt = '0; m_data = '0; m_updn = 1'b0; m_err = 1'b0;
      end
    end
    @(posedge clk5m);
    if (!model_ok && !rst_n) model_ok = 1'b1;
    #1;
  endtask

  task automatic snap();
    s_busy = tot_busy; s_en = tot_en; s_load = tot_load; s_done = tot_done; s_tog = tot_tog;
  endtask

  task automatic do_start(input logic md, input logic dr, input logic [9:0] lo,
                          input logic [9:0] hi, input logic [7:0] dw, input logic [7:0] n);
    mode = md; dir_init = dr; lo_val = lo; hi_val = hi; dwell = dw; n_sweeps = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble config to show it is only sampled at the accepted start.
    mode = 1'($urandom); dir_init = 1'($urandom); lo_val = 10'($urandom);
    hi_val = 10'($urandom); dwell = 8'($urandom); n_sweeps = 8'($urandom);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int k = 0;
    while (q.size() != 0 && k < bound) begin
      tick();
      k++;
    end
    chk({name, " finished in budget"}, q.size(), 0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; dir_init = 1'b0;
    lo_val = '0; hi_val = '0; dwell = '0; n_sweeps = '0;
    tick(); tick();
    rst_n = 1'b1;
    chk("reset busy", busy, 0);
    chk("reset err", err, 0);
    chk("reset cnt", cnt, 0);
    chk("reset cnt_data", cnt_data, 0);
    tick();

    // Single sweep up 5 -> 12.
    snap();
    do_start(0, 0, 10'd5, 10'd12, 8'd0, 8'd0);
    wait_idle("t1", 100);
    chk("t1 busy cycles", tot_busy - s_busy, 10);
    chk("t1 en cycles", tot_en - s_en, 7);
    chk("t1 loads", tot_load - s_load, 1);
    chk("t1 load data", last_load_data, 5);
    chk("t1 done pulses", tot_done - s_done, 1);
    chk("t1 final cnt", cnt, 12);
    tick();

    // Triangle 0..3, three traversals, dwell 2.
    snap();
    do_start(1, 0, 10'd0, 10'd3, 8'd2, 8'd3);
    wait_idle("t2", 100);
    chk("t2 busy cycles", tot_busy - s_busy, 20);
    chk("t2 en cycles", tot_en - s_en, 9);
    chk("t2 dir toggles", tot_tog - s_tog, 2);
    chk("t2 final cnt", cnt, 3);
    chk("t2 done pulses", tot_done - s_done, 1);

    // Reversed bounds rejected, then a valid start clears err; start while busy ignored.
    snap();
    do_start(0, 0, 10'd900, 10'd100, 8'd0, 8'd0);
    tick();
    chk("t3 err set", err, 1);
    chk("t3 busy", busy, 0);
    chk("t3 no load", tot_load - s_load, 0);
    do_start(0, 0, 10'd2, 10'd6, 8'd1, 8'd0);
    chk("t3 err cleared", err, 0);
    tick(); tick();
    do_start(1, 1, 10'd0, 10'd1, 8'd0, 8'd0);
    wait_idle("t3", 100);
    chk("t3 final cnt", cnt, 6);
    chk("t3 done pulses", tot_done - s_done, 1);

    // Degenerate lo = hi = 1023, then full-range sweep down.
    snap();
    do_start(0, 0, 10'd1023, 10'd1023, 8'd0, 8'd0);
    wait_idle("t4a", 100);
    chk("t4a busy cycles", tot_busy - s_busy, 3);
    chk("t4a en cycles", tot_en - s_en, 0);
    chk("t4a final cnt", cnt, 1023);
    snap();
    do_start(0, 1, 10'd0, 10'd1023, 8'd0, 8'd0);
    wait_idle("t4b", 1200);
    chk("t4b en cycles", tot_en - s_en, 1023);
    chk("t4b final cnt", cnt, 0);

    // Endless triangle aborted at cnt = 15.
    do_start(1, 0, 10'd10, 10'd20, 8'd1, 8'd0);
    k = 0;
    while (!(busy && cnt == 10'd15) && k < 200) begin
      tick();
      k++;
    end
    chk("t5 reached 15", cnt, 15);
    snap();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5 busy after abort", busy, 0);
    chk("t5 en after abort", cnt_en, 0);
    chk("t5 cnt held", cnt, 15);
    tick(); tick();
    chk("t5 no done", tot_done - s_done, 0);
    snap();
    mode = 1'b0; dir_init = 1'b0; lo_val = 10'd1; hi_val = 10'd4;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    chk("t5 start+abort idle", busy, 0);
    chk("t5 start+abort no load", tot_load - s_load, 0);

    // Reset in the middle of a dwell.
    do_start(1, 0, 10'd0, 10'd4, 8'd50, 8'd2);
    k = 0;
    while (!(busy && cnt == 10'd4) && k < 100) begin
      tick();
      k++;
    end
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6 busy", busy, 0);
    chk("t6 cnt", cnt, 0);
    chk("t6 cnt_data", cnt_data, 0);
    chk("t6 err", err, 0);
    snap();
    do_start(0, 0, 10'd3, 10'd8, 8'd0, 8'd0);
    wait_idle("t6", 100);
    chk("t6 final cnt", cnt, 8);
    chk("t6 done pulses", tot_done - s_done, 1);

    // Randomized programs, occasional bad bounds and aborts.
    for (int it = 0; it < 30; it++) begin
      logic [9:0] lo, hi, tmp;
      int         hv;
      lo = 10'($urandom_range(0, 1023));
      hv = int'(lo) + int'($urandom_range(0, 12));
      hi = (hv > 1023) ? 10'd1023 : 10'(hv);
      if ($urandom_range(0, 7) == 0) begin
        tmp = lo; lo = hi; hi = tmp;
      end
      do_start(1'($urandom), 1'($urandom), lo, hi, 8'($urandom_range(0, 3)),
               8'($urandom_range(1, 4)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 6)) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end
      wait_idle("rand", 2000);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
